punc_datapath: RTL and testbench
================================

Name: punc_datapath

Overview:
- LC3 PUnC datapath, directly downstream of the control FSM.
- Consumes every control strobe and select the FSM drives, and returns ir and the n/z/p condition codes to it.
- Holds the PC, IR, the 8x16 register file, the ALU, the condition codes and all address/data muxes.
- Drives an external word-addressed memory: asynchronous read, write committed on the next posedge.

Parameters:
- PC_INIT, 16'h0000, value loaded into PC by reset and by pc_clr.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- mem_w_en  in  1  memory write strobe
- mem_w_addr_sel  in  1  memory write address select
- mem_w_data_sel  in  1  memory write data select
- mem_r_addr_sel  in  2  memory read address select
- rf_w_en  in  1  register file write enable
- rf_r0_addr_sel  in  1  read port 0 address select
- rf_r1_addr_sel  in  1  read port 1 address select
- rf_w_data_sel  in  2  register write data select
- rf_w_addr_sel  in  1  register write address select
- ir_ld  in  1  load IR from memory
- pc_ld  in  1  load PC
- pc_clr  in  1  clear PC to PC_INIT
- pc_inc  in  1  PC+1
- pc_ld_data_sel  in  2  PC load source select
- alu_sel  in  3  ALU function select
- cond_ld  in  1  load condition codes
- cond_ld_data_sel  in  1  condition code source select
- ir  out  16  instruction register
- n, z, p  out  1 each  condition codes
- mem_r_addr  out  16  memory read address
- mem_r_data  in  16  memory read data (combinational)
- mem_w_addr  out  16  memory write address
- mem_w_data  out  16  memory write data
- mem_wr  out  1  memory write enable (equals mem_w_en)
- dbg_r_addr  in  3  debug register select
- dbg_r_data  out  16  RF[dbg_r_addr] (combinational)
- dbg_pc  out  16  current PC

Behaviour:
- Reset (rst high at posedge):
  - PC=PC_INIT, IR=0, RF[0..7]=0.
  - n=0, z=1, p=0.
  - Reset overrides every control input, including a write in flight.
- Sign extension: sext5=ir[4:0], sext6=ir[5:0], sext9=ir[8:0], sext11=ir[10:0], each to 16 bits.
- Adders are 16-bit, modulo 2^16; carries are discarded and wrap is silent.
- Derived addresses:
  - pcoff9 = PC + sext9
  - pcoff11 = PC + sext11
- Read port addresses:
  - r0: sel 0 = ir[8:6]; sel 1 = ir[11:9].
  - r1: sel 0 = ir[2:0]; sel 1 = ir[8:6].
- RF read timing:
  - Reads are combinational.
  - A write becomes visible only after the posedge.
  - A same-cycle read of the register being written returns the old value.
- RF write address: sel 0 = ir[11:9]; sel 1 = 3'd7.
- RF write data:
  - 0 = ALU out
  - 1 = mem_r_data
  - 2 = PC
  - 3 = pcoff9 (LEA)
- ALU (combinational, a = r0 data):
  - 0: a + r1
  - 1: a + sext5
  - 2: a & r1
  - 3: a & sext5
  - 4: ~a
  - 5: pass a
  - 6, 7: output 0
- mem_r_addr: 0 = PC; 1 = pcoff9; 2 = r0 + sext6; 3 = PC.
- mem_w_addr: 0 = pcoff9; 1 = r1 + sext6.
- mem_w_data: r0 data for both select values.
- PC update at posedge, priority pc_clr > pc_ld > pc_inc, else hold.
  - Load sources: 0 = pcoff9; 1 = r0 data; 2 = pcoff11; 3 = PC (hold).
  - PC-relative values use the current PC, which the control unit has already incremented during decode.
- IR: ir_ld loads mem_r_data at posedge; otherwise IR holds.
- Condition codes:
  - On cond_ld, the source is ALU out (sel 0) or the RF write-data mux output (sel 1).
  - n = bit15; z = (value == 0); p = !n & !z.
  - Exactly one of n/z/p is 1 at all times.
- Independence and simultaneous events:
  - Strobes are independent; any combination in one cycle applies all updates at the same posedge from pre-edge values.
  - Example: rf_w_en with rf_w_data_sel=2 together with pc_ld writes the old PC into the RF (JSR linkage).
- No internal state machine; all sequencing comes from the control unit. Registers change only at posedge.

Test Plan:
- Reset: hold rst 2 cycles with all strobes high -> PC=0, ir=0, z=1, n=p=0, dbg_r_data=0 for all 8 addresses.
- Fetch/ADD imm:
  - Stimulus: mem_r_data=16'h1261 with ir_ld, then pc_inc, then alu_sel=1, rf_w_en, rf_w_data_sel=0, cond_ld.
  - Response: ir=16'h1261, PC=1, R1=1, p=1.
- PC priority:
  - pc_clr+pc_ld+pc_inc in one cycle -> PC=PC_INIT.
  - pc_ld(sel1, r0=16'h1234)+pc_inc -> PC=16'h1234.
- BR wrap: PC=16'h0001, ir=16'h0FFE, pc_ld sel0 -> PC=16'hFFFF.
- JSR link:
  - Stimulus: PC=16'h3001, ir=16'h4802, rf_w_data_sel=2, rf_w_addr_sel=1, rf_w_en, pc_ld sel2.
  - Response: R7=16'h3001, PC=16'h3003.
- STR then LDR:
  - STR stimulus: R2=16'h4000, R3=16'h8000, ir=16'h76BF, mem_w_en, mem_w_addr_sel=1, r0 sel1, r1 sel1.
  - STR response: mem_w_addr=16'h3FFF, mem_w_data=16'h8000, mem_wr=1.
  - LDR stimulus: ir=16'h66BF, mem_r_addr_sel=2, rf_w_data_sel=1, cond sel1.
  - LDR response: mem_r_addr=16'h3FFF, R3=mem_r_data, n=1 when mem_r_data=16'h8000.

Source files
------------

// File: rtl/punc_datapath.sv
// LC3 PUnC datapath: PC, IR, 8x16 register file, ALU, condition codes and memory address/data muxing.
// Every register update is steered by control strobes from the external control FSM.
module punc_datapath #(
    parameter logic [15:0] PC_INIT = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_w_en,
    input  logic        mem_w_addr_sel,
    input  logic        mem_w_data_sel,
    input  logic [1:0]  mem_r_addr_sel,
    input  logic        rf_w_en,
    input  logic        rf_r0_addr_sel,
    input  logic        rf_r1_addr_sel,
    input  logic [1:0]  rf_w_data_sel,
    input  logic        rf_w_addr_sel,
    input  logic        ir_ld,
    input  logic        pc_ld,
    input  logic        pc_clr,
    input  logic        pc_inc,
    input  logic [1:0]  pc_ld_data_sel,
    input  logic [2:0]  alu_sel,
    input  logic        cond_ld,
    input  logic        cond_ld_data_sel,
    output logic [15:0] ir,
    output logic        n,
    output logic        z,
    output logic        p,
    output logic [15:0] mem_r_addr,
    input  logic [15:0] mem_r_data,
    output logic [15:0] mem_w_addr,
    output logic [15:0] mem_w_data,
    output logic        mem_wr,
    input  logic [2:0]  dbg_r_addr,
    output logic [15:0] dbg_r_data,
    output logic [15:0] dbg_pc
);

    logic [15:0] pc;
    logic [15:0] rf [8];

    logic [15:0] sext5, sext6, sext9, sext11;
    logic [15:0] pcoff9, pcoff11;
    logic [2:0]  r0_addr, r1_addr, rf_w_addr;
    logic [15:0] r0_data, r1_data;
    logic [15:0] alu_out, rf_w_data, pc_ld_data, cond_src;

    assign sext5  = {{11{ir[4]}}, ir[4:0]};
    assign sext6  = {{10{ir[5]}}, ir[5:0]};
    assign sext9  = {{7{ir[8]}},  ir[8:0]};
    assign sext11 = {{5{ir[10]}}, ir[10:0]};

    assign pcoff9  = pc + sext9;
    assign pcoff11 = pc + sext11;

    assign r0_addr   = rf_r0_addr_sel ? ir[11:9] : ir[8:6];
    assign r1_addr   = rf_r1_addr_sel ? ir[8:6]  : ir[2:0];
    assign rf_w_addr = rf_w_addr_sel  ? 3'd7     : ir[11:9];

    // Reads see the pre-edge array, so a same-cycle write is not bypassed.
    assign r0_data    = rf[r0_addr];
    assign r1_data    = rf[r1_addr];
    assign dbg_r_data = rf[dbg_r_addr];

    always_comb begin
        alu_out = '0;
        case (alu_sel)
            3'd0:    alu_out = r0_data + r1_data;
            3'd1:    alu_out = r0_data + sext5;
            3'd2:    alu_out = r0_data & r1_data;
            3'd3:    alu_out = r0_data & sext5;
            3'd4:    alu_out = ~r0_data;
            3'd5:    alu_out = r0_data;
            default: alu_out = '0;
        endcase
    end

    always_comb begin
        rf_w_data = '0;
        case (rf_w_data_sel)
            2'd0:    rf_w_data = alu_out;
            2'd1:    rf_w_data = mem_r_data;
            2'd2:    rf_w_data = pc;
            default: rf_w_data = pcoff9;
        endcase
    end

    always_comb begin
        pc_ld_data = pc;
        case (pc_ld_data_sel)
            2'd0:    pc_ld_data = pcoff9;
            2'd1:    pc_ld_data = r0_data;
            2'd2:    pc_ld_data = pcoff11;
            default: pc_ld_data = pc;
        endcase
    end

    always_comb begin
        mem_r_addr = pc;
        case (mem_r_addr_sel)
            2'd1:    mem_r_addr = pcoff9;
            2'd2:    mem_r_addr = r0_data + sext6;
            default: mem_r_addr = pc;
        endcase
    end

    assign mem_w_addr = mem_w_addr_sel ? (r1_data + sext6) : pcoff9;
    // Both store flavours write the r0 operand, so the select has no effect on the data.
    assign mem_w_data = mem_w_data_sel ? r0_data : r0_data;
    assign mem_wr     = mem_w_en;
    assign dbg_pc     = pc;

    assign cond_src = cond_ld_data_sel ? rf_w_data : alu_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= PC_INIT;
        end else if (pc_clr) begin
            pc <= PC_INIT;
        end else if (pc_ld) begin
            pc <= pc_ld_data;
        end else if (pc_inc) begin
            pc <= pc + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir <= '0;
        end else if (ir_ld) begin
            ir <= mem_r_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 8; i++) begin
                rf[i] <= '0;
            end
        end else if (rf_w_en) begin
            rf[rf_w_addr] <= rf_w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n <= 1'b0;
            z <= 1'b1;
            p <= 1'b0;
        end else if (cond_ld) begin
            n <= cond_src[15];
            z <= (cond_src == 16'h0000);
            p <= !cond_src[15] && (cond_src != 16'h0000);
        end
    end

endmodule

// File: tb/tb_punc_datapath.sv
// Directed bench for punc_datapath: expectations queued at stimulus time, popped when outputs are sampled.
// A 16-word memory model (low address bits) backs the store/load sequence.
module tb_punc_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_w_en, mem_w_addr_sel, mem_w_data_sel;
    logic [1:0]  mem_r_addr_sel;
    logic        rf_w_en, rf_r0_addr_sel, rf_r1_addr_sel;
    logic [1:0]  rf_w_data_sel;
    logic        rf_w_addr_sel, ir_ld, pc_ld, pc_clr, pc_inc;
    logic [1:0]  pc_ld_data_sel;
    logic [2:0]  alu_sel;
    logic        cond_ld, cond_ld_data_sel;
    logic [15:0] ir;
    logic        n, z, p;
    logic [15:0] mem_r_addr, mem_r_data, mem_w_addr, mem_w_data;
    logic        mem_wr;
    logic [2:0]  dbg_r_addr;
    logic [15:0] dbg_r_data, dbg_pc;

    logic        use_mem;
    logic [15:0] drv_data;
    logic [15:0] mem [16];

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr) mem[mem_w_addr[3:0]] <= mem_w_data;
    end

    assign mem_r_data = use_mem ? mem[mem_r_addr[3:0]] : drv_data;

    punc_datapath #(.PC_INIT(16'h0000)) dut (
        .clk(clk), .rst(rst),
        .mem_w_en(mem_w_en), .mem_w_addr_sel(mem_w_addr_sel), .mem_w_data_sel(mem_w_data_sel),
        .mem_r_addr_sel(mem_r_addr_sel),
        .rf_w_en(rf_w_en), .rf_r0_addr_sel(rf_r0_addr_sel), .rf_r1_addr_sel(rf_r1_addr_sel),
        .rf_w_data_sel(rf_w_data_sel), .rf_w_addr_sel(rf_w_addr_sel),
        .ir_ld(ir_ld), .pc_ld(pc_ld), .pc_clr(pc_clr), .pc_inc(pc_inc),
        .pc_ld_data_sel(pc_ld_data_sel), .alu_sel(alu_sel),
        .cond_ld(cond_ld), .cond_ld_data_sel(cond_ld_data_sel),
        .ir(ir), .n(n), .z(z), .p(p),
        .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data),
        .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data), .mem_wr(mem_wr),
        .dbg_r_addr(dbg_r_addr), .dbg_r_data(dbg_r_data), .dbg_pc(dbg_pc)
    );

    task automatic push_exp(input string tag, input logic [15:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic compare(input logic [15:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_underflow observed=%h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_w_en = 0; mem_w_addr_sel = 0; mem_w_data_sel = 0; mem_r_addr_sel = 2'd0;
        rf_w_en = 0; rf_r0_addr_sel = 0; rf_r1_addr_sel = 0; rf_w_data_sel = 2'd0;
        rf_w_addr_sel = 0; ir_ld = 0; pc_ld = 0; pc_clr = 0; pc_inc = 0;
        pc_ld_data_sel = 2'd0; alu_sel = 3'd0; cond_ld = 0; cond_ld_data_sel = 0;
    endtask

    task automatic load_ir(input logic [15:0] v);
        idle();
        drv_data = v;
        ir_ld = 1;
        tick();
        idle();
    endtask

    // Leaves IR = {4'h0, k, 9'h0}, so r0 with select 1 addresses Rk afterwards.
    task automatic set_reg(input logic [2:0] k, input logic [15:0] v);
        load_ir({4'h0, k, 9'h000});
        drv_data = v;
        rf_w_en = 1;
        rf_w_data_sel = 2'd1;
        tick();
        idle();
    endtask

    task automatic set_pc(input logic [15:0] v);
        set_reg(3'd4, v);
        rf_r0_addr_sel = 1;
        pc_ld = 1;
        pc_ld_data_sel = 2'd1;
        tick();
        idle();
    endtask

    task automatic check_reg(input string tag, input logic [2:0] k, input logic [15:0] v);
        dbg_r_addr = k;
        #1;
        push_exp(tag, v);
        compare(dbg_r_data);
    endtask

    task automatic check_nzp(input string tag, input logic [2:0] nzp);
        push_exp({tag, "_n"}, {15'b0, nzp[2]}); compare({15'b0, n});
        push_exp({tag, "_z"}, {15'b0, nzp[1]}); compare({15'b0, z});
        push_exp({tag, "_p"}, {15'b0, nzp[0]}); compare({15'b0, p});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        use_mem = 0;
        dbg_r_addr = 3'd0;
        // Reset with every strobe asserted and a nonzero write in flight.
        rst = 1;
        drv_data = 16'hFFFF;
        mem_w_en = 1; mem_w_addr_sel = 1; mem_w_data_sel = 1; mem_r_addr_sel = 2'd3;
        rf_w_en = 1; rf_r0_addr_sel = 1; rf_r1_addr_sel = 1; rf_w_data_sel = 2'd1;
        rf_w_addr_sel = 1; ir_ld = 1; pc_ld = 1; pc_clr = 1; pc_inc = 1;
        pc_ld_data_sel = 2'd2; alu_sel = 3'd4; cond_ld = 1; cond_ld_data_sel = 1;
        tick();
        tick();
        rst = 0;
        idle();
        push_exp("reset_pc", 16'h0000); compare(dbg_pc);
        push_exp("reset_ir", 16'h0000); compare(ir);
        check_nzp("reset", 3'b010);
        for (int i = 0; i < 8; i++) check_reg("reset_rf", i[2:0], 16'h0000);

        // Fetch and ADD R1, R1, #1
        load_ir(16'h1261);
        push_exp("fetch_ir", 16'h1261); compare(ir);
        pc_inc = 1;
        tick();
        idle();
        push_exp("fetch_pc_inc", 16'h0001); compare(dbg_pc);
        alu_sel = 3'd1; rf_w_en = 1; rf_w_data_sel = 2'd0; cond_ld = 1;
        check_reg("add_old_value_before_edge", 3'd1, 16'h0000);
        tick();
        idle();
        check_reg("add_r1", 3'd1, 16'h0001);
        check_nzp("add", 3'b001);

        // PC update priority
        set_reg(3'd2, 16'h1234);
        pc_clr = 1; pc_ld = 1; pc_inc = 1; pc_ld_data_sel = 2'd1; rf_r0_addr_sel = 1;
        tick();
        idle();
        push_exp("pc_clr_wins", 16'h0000); compare(dbg_pc);
        pc_ld = 1; pc_inc = 1; pc_ld_data_sel = 2'd1; rf_r0_addr_sel = 1;
        tick();
        idle();
        push_exp("pc_ld_over_inc", 16'h1234); compare(dbg_pc);

        // BR with negative offset wrapping below zero
        pc_clr = 1; tick(); idle();
        pc_inc = 1; tick(); idle();
        load_ir(16'h0FFE);
        mem_r_addr_sel = 2'd1;
        #1;
        push_exp("pcoff9_rd_addr_wrap", 16'hFFFF); compare(mem_r_addr);
        pc_ld = 1; pc_ld_data_sel = 2'd0;
        tick();
        idle();
        push_exp("br_wrap_pc", 16'hFFFF); compare(dbg_pc);

        // JSR: link old PC into R7 while PC takes pcoff11
        set_pc(16'h3001);
        load_ir(16'h4802);
        rf_w_data_sel = 2'd2; rf_w_addr_sel = 1; rf_w_en = 1; pc_ld = 1; pc_ld_data_sel = 2'd2;
        tick();
        idle();
        check_reg("jsr_r7_link", 3'd7, 16'h3001);
        push_exp("jsr_pc", 16'h3003); compare(dbg_pc);

        // STR R3, R2, #-1
        set_reg(3'd2, 16'h4000);
        set_reg(3'd3, 16'h8000);
        load_ir(16'h76BF);
        mem_w_en = 1; mem_w_addr_sel = 1; mem_w_data_sel = 1; rf_r0_addr_sel = 1; rf_r1_addr_sel = 1;
        #1;
        push_exp("str_w_addr", 16'h3FFF); compare(mem_w_addr);
        push_exp("str_w_data", 16'h8000); compare(mem_w_data);
        push_exp("str_wr", 16'h0001); compare({15'b0, mem_wr});
        tick();
        idle();
        set_reg(3'd3, 16'h0000);
        check_reg("r3_cleared", 3'd3, 16'h0000);

        // LDR R3, R2, #-1 reads back the stored word
        load_ir(16'h66BF);
        use_mem = 1;
        mem_r_addr_sel = 2'd2; rf_w_data_sel = 2'd1; rf_w_en = 1; cond_ld = 1; cond_ld_data_sel = 1;
        #1;
        push_exp("ldr_r_addr", 16'h3FFF); compare(mem_r_addr);
        push_exp("ldr_r_data", 16'h8000); compare(mem_r_data);
        tick();
        idle();
        use_mem = 0;
        check_reg("ldr_r3", 3'd3, 16'h8000);
        check_nzp("ldr", 3'b100);

        // AND R5, R3, R2 -> 0
        load_ir(16'h5AC2);
        alu_sel = 3'd2; rf_w_en = 1; cond_ld = 1;
        tick();
        idle();
        check_reg("and_r5", 3'd5, 16'h0000);
        check_nzp("and", 3'b010);

        // NOT R6, R3 then alu_sel 6 forces zero
        load_ir(16'h9CFF);
        alu_sel = 3'd6; rf_w_en = 1; cond_ld = 1;
        tick();
        idle();
        check_reg("alu6_r6", 3'd6, 16'h0000);
        alu_sel = 3'd4; rf_w_en = 1; cond_ld = 1;
        tick();
        idle();
        check_reg("not_r6", 3'd6, 16'h7FFF);
        check_nzp("not", 3'b001);

        // Mid-run reset beats a concurrent write, load and fetch
        rst = 1;
        drv_data = 16'hBEEF;
        rf_w_en = 1; rf_w_data_sel = 2'd1; rf_w_addr_sel = 1; pc_inc = 1; ir_ld = 1; cond_ld = 1;
        tick();
        rst = 0;
        idle();
        push_exp("rst2_pc", 16'h0000); compare(dbg_pc);
        push_exp("rst2_ir", 16'h0000); compare(ir);
        check_reg("rst2_r7", 3'd7, 16'h0000);
        check_reg("rst2_r6", 3'd6, 16'h0000);
        check_nzp("rst2", 3'b010);

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
